// File: rtl/pwl_act_pkg.sv
// Shared widths and table helpers for the piecewise-linear activation unit.
// next_index is also used by the bench model so both agree on clamp/wrap.
package pwl_act_pkg;

   localparam int unsigned DATA_W_DEF = 8;
   localparam int unsigned ADDR_W_DEF = 4;
   localparam int unsigned FRAC_W_DEF = 4;

   // Reset table entry: index read as two's complement, scaled to the output range.
   function automatic int ramp_entry(input int i,
                                     input int addr_w = int'(ADDR_W_DEF),
                                     input int data_w = int'(DATA_W_DEF));
      int s;
      s = i & ((1 << addr_w) - 1);
      if (s >= (1 << (addr_w - 1)))
         s = s - (1 << addr_w);
      return s <<< (data_w - addr_w);
   endfunction

   // Upper interpolation point: flat past the largest positive index, -1 wraps to 0.
   function automatic int next_index(input int idx,
                                     input int addr_w = int'(ADDR_W_DEF));
      if (idx == (1 << (addr_w - 1)) - 1)
         return idx;
      return (idx + 1) % (1 << addr_w);
   endfunction

endpackage

// File: rtl/pwl_act_if.sv
// Sample stream and LUT write port of the activation unit.
interface pwl_act_if
   import pwl_act_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned FRAC_W = FRAC_W_DEF
) ();

   logic                       in_valid;
   logic                       in_ready;
   logic [ADDR_W+FRAC_W-1:0]   in_x;
   logic                       out_valid;
   logic                       out_ready;
   logic [DATA_W-1:0]          out_y;
   logic                       wr_en;
   logic [ADDR_W-1:0]          wr_addr;
   logic [DATA_W-1:0]          wr_data;

   modport master (
      output in_valid, in_x, out_ready, wr_en, wr_addr, wr_data,
      input  in_ready, out_valid, out_y
   );

   modport slave (
      input  in_valid, in_x, out_ready, wr_en, wr_addr, wr_data,
      output in_ready, out_valid, out_y
   );

endinterface

// File: rtl/pwl_act_lut.sv
// Run-time loadable activation table: one write port, base/next read ports.
// Resets to the identity ramp.
module pwl_act_lut
   import pwl_act_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic signed [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0]        rd_idx,
   output logic signed [DATA_W-1:0] rd_base,
   output logic signed [DATA_W-1:0] rd_next
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic signed [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0]        next_idx_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++)
            mem[i] <= DATA_W'(ramp_entry(i, int'(ADDR_W), int'(DATA_W)));
      end else if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_comb begin
      next_idx_c = ADDR_W'(next_index(int'(rd_idx), int'(ADDR_W)));
      rd_base    = mem[rd_idx];
      rd_next    = mem[next_idx_c];
   end

endmodule

// File: rtl/pwl_act_pipe.sv
// Three-stage piecewise-linear activation: lookup, scale, round-and-add.
// All stages share one stall; in_ready depends only on the output stage.
module pwl_act_pipe
   import pwl_act_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned FRAC_W = FRAC_W_DEF
) (
   input  logic     clk,
   input  logic     rst_n,
   pwl_act_if.slave bus
);

   localparam int unsigned X_W = ADDR_W + FRAC_W;
   localparam int unsigned P_W = DATA_W + FRAC_W + 2;

   logic                     advance;
   logic [ADDR_W-1:0]        idx_c;
   logic signed [DATA_W-1:0] lut_base;
   logic signed [DATA_W-1:0] lut_next;

   logic                     v0;
   logic signed [DATA_W-1:0] base0;
   logic signed [DATA_W-1:0] next0;
   logic [FRAC_W-1:0]        frac0;

   logic                     v1;
   logic signed [P_W-1:0]    prod1;
   logic signed [DATA_W-1:0] base1;

   logic                     v2;
   logic [DATA_W-1:0]        y2;

   logic signed [P_W-1:0]    diff_c;
   logic signed [P_W-1:0]    frac_c;
   logic signed [P_W-1:0]    prod_c;
   logic signed [P_W-1:0]    rnd_c;
   logic signed [P_W-1:0]    delta_c;
   logic signed [P_W-1:0]    sum_c;

   assign advance       = !v2 || bus.out_ready;
   assign bus.in_ready  = advance;
   assign bus.out_valid = v2;
   assign bus.out_y     = y2;
   assign idx_c         = bus.in_x[X_W-1:FRAC_W];

   pwl_act_lut #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_lut (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (bus.wr_en),
      .wr_addr (bus.wr_addr),
      .wr_data (bus.wr_data),
      .rd_idx  (idx_c),
      .rd_base (lut_base),
      .rd_next (lut_next)
   );

   // Interpolation arithmetic; the result stays between base and next so no saturation.
   always_comb begin
      diff_c  = P_W'(next0) - P_W'(base0);
      frac_c  = P_W'({1'b0, frac0});
      prod_c  = diff_c * frac_c;
      rnd_c   = prod1 + P_W'(1 << (FRAC_W - 1));
      delta_c = rnd_c >>> FRAC_W;
      sum_c   = P_W'(base1) + delta_c;
   end

   // S0: table lookup
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v0    <= 1'b0;
         base0 <= '0;
         next0 <= '0;
         frac0 <= '0;
      end else if (advance) begin
         v0    <= bus.in_valid;
         base0 <= lut_base;
         next0 <= lut_next;
         frac0 <= bus.in_x[FRAC_W-1:0];
      end
   end

   // S1: scaled difference
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1    <= 1'b0;
         prod1 <= '0;
         base1 <= '0;
      end else if (advance) begin
         v1    <= v0;
         prod1 <= prod_c;
         base1 <= base0;
      end
   end

   // S2: result register; y only loads real samples so it holds across bubbles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2 <= 1'b0;
         y2 <= '0;
      end else if (advance) begin
         v2 <= v1;
         if (v1)
            y2 <= sum_c[DATA_W-1:0];
      end
   end

endmodule

// File: tb/tb_pwl_act_pipe.sv
// Scoreboard bench for pwl_act_pipe: expected results are queued at acceptance
// from a reference table model and compared as outputs are consumed.
module tb_pwl_act_pipe;
   import pwl_act_pkg::*;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 4;
   localparam int FRAC_W = 4;
   localparam int DEPTH  = 1 << ADDR_W;

   logic clk = 1'b0;
   logic rst_n;

   pwl_act_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FRAC_W(FRAC_W)) bus ();

   pwl_act_pipe #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FRAC_W(FRAC_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int mlut [DEPTH];
   int sb [$];
   bit acc;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++)
         mlut[i] = ramp_entry(i, ADDR_W, DATA_W);
   endtask

   function automatic int model_y(input logic [ADDR_W+FRAC_W-1:0] x);
      int idx, frac, base, nxt, d, y;
      logic [DATA_W-1:0] t;
      idx  = int'(x[ADDR_W+FRAC_W-1:FRAC_W]);
      frac = int'(x[FRAC_W-1:0]);
      base = mlut[idx];
      nxt  = mlut[next_index(idx, ADDR_W)];
      d    = ((nxt - base) * frac + (1 << (FRAC_W - 1))) >>> FRAC_W;
      y    = base + d;
      t    = DATA_W'(y);
      return int'($signed(t));
   endfunction

   // One cycle: called just after a falling edge with inputs already driven.
   task automatic tick();
      int e;
      #1;
      acc = bus.in_valid && bus.in_ready;
      if (acc)
         sb.push_back(model_y(bus.in_x));
      if (bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) begin
            check_eq("unexpected_out", int'(bus.out_valid), 0);
         end else begin
            e = sb.pop_front();
            check_eq("out_y", int'($signed(bus.out_y)), e);
         end
      end
      if (bus.wr_en)
         mlut[int'(bus.wr_addr)] = int'($signed(bus.wr_data));
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic lut_write(input int addr, input int data);
      bus.wr_en   = 1'b1;
      bus.wr_addr = ADDR_W'(addr);
      bus.wr_data = DATA_W'(data);
      tick();
      bus.wr_en   = 1'b0;
   endtask

   task automatic send(input int x);
      int n;
      bus.in_valid = 1'b1;
      bus.in_x     = (ADDR_W+FRAC_W)'(x);
      n = 0;
      do begin
         tick();
         n++;
      end while (!acc && n < 50);
      if (!acc)
         check_eq("accept_timeout", n, 0);
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b0;
      n = 0;
      while (sb.size() != 0 && n < 40) begin
         tick();
         n++;
      end
      check_eq("drain_left", sb.size(), 0);
   endtask

   initial begin
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_x     = '0;
      bus.out_ready = 1'b1;
      bus.wr_en    = 1'b0;
      bus.wr_addr  = '0;
      bus.wr_data  = '0;
      model_reset();

      // Reset state
      #12;
      check_eq("rst_out_valid", int'(bus.out_valid), 0);
      check_eq("rst_in_ready",  int'(bus.in_ready), 1);
      check_eq("rst_out_y",     int'($signed(bus.out_y)), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // 1: identity with exact latency
      bus.in_valid = 1'b1;
      bus.in_x     = 8'h25;
      tick();
      check_eq("t1_accept", int'(acc), 1);
      bus.in_valid = 1'b0;
      tick();
      check_eq("t1_lat_early", int'(bus.out_valid), 0);
      tick();
      check_eq("t1_lat_valid", int'(bus.out_valid), 1);
      check_eq("t1_y37", int'($signed(bus.out_y)), 37);
      drain();

      // 2: positive clamp; 3: -1 wraps to entry 0
      send(8'h7A);
      send(8'h70);
      send(8'hF8);
      send(8'h80);
      drain();
      check_eq("t3_y_hold", int'($signed(bus.out_y)), -128);

      // 4: interpolation with rounding, consecutive writes to one index
      lut_write(2, 100);
      lut_write(3, -100);
      send(8'h28);
      drain();
      lut_write(2, -100);
      lut_write(3, 100);
      send(8'h28);
      drain();
      lut_write(2, -50);
      lut_write(2, 10);
      lut_write(3, 11);
      send(8'h28);
      drain();
      check_eq("t4_half_up", int'($signed(bus.out_y)), 11);

      // 5: back-to-back stream against a 6-cycle stall, with a write to a live index
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      for (int x = 1; x <= 3; x++) begin
         bus.in_x = 8'(x);
         tick();
         check_eq("t5_fill_accept", int'(acc), 1);
      end
      bus.in_x = 8'h04;
      for (int c = 0; c < 3; c++) begin
         #1;
         check_eq("t5_stall_ready", int'(bus.in_ready), 0);
         check_eq("t5_stall_valid", int'(bus.out_valid), 1);
         bus.wr_en   = (c == 0);
         bus.wr_addr = 4'd1;
         bus.wr_data = 8'd48;
         tick();
      end
      bus.wr_en     = 1'b0;
      bus.out_ready = 1'b1;
      send(8'h04);
      send(8'h05);
      drain();
      check_eq("t5_last_y", int'($signed(bus.out_y)), 15);

      // 6: reset mid-stream drops in-flight samples and reloads the ramp
      lut_write(2, 100);
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      for (int x = 0; x < 3; x++) begin
         bus.in_x = 8'(32 + x);
         tick();
      end
      bus.in_valid = 1'b0;
      check_eq("t6_pre_valid", int'(bus.out_valid), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("t6_async_drop", int'(bus.out_valid), 0);
      sb.delete();
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      send(8'h20);
      drain();
      check_eq("t6_ramp_back", int'($signed(bus.out_y)), 32);
      for (int c = 0; c < 4; c++) begin
         tick();
         check_eq("t6_no_stale", int'(bus.out_valid), 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pwl_act_pipe.md
# pwl_act_pipe

Parametrised, pipelined piecewise-linear activation unit for the neural-network layers. A signed fixed-point input is split into a LUT index and a fraction. The block looks up the segment base and next points, linearly interpolates between them, and returns the activation through a valid/ready stream. It replaces the fixed 16-entry combinational activation LUT: the table is run-time loadable, so one instance serves tanh, sigmoid or any other monotone curve. Each layer's func stage instantiates it after the weighted-sum accumulator.

## Interface
- `DATA_W`, 8: signed width of LUT entries and of the output.
- `ADDR_W`, 4: LUT index bits. Depth is 2^ADDR_W. Index is two's-complement.
- `FRAC_W`, 4: fraction bits. Input width is ADDR_W+FRAC_W.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `in_valid`  in  1: input sample valid.
- `in_ready`  out  1: block accepts a sample this cycle.
- `in_x`  in  ADDR_W+FRAC_W: signed input. Upper ADDR_W bits are the index, lower FRAC_W bits are the unsigned fraction.
- `out_valid`  out  1: result valid.
- `out_ready`  in  1: downstream accepts result.
- `out_y`  out  DATA_W: signed interpolated result.
- `wr_en`  in  1: LUT write strobe.
- `wr_addr`  in  ADDR_W: LUT write index.
- `wr_data`  in  DATA_W: signed LUT write value.

## Operation
- LUT is a 2^ADDR_W × DATA_W signed register array.
- Reset ramp: entry i = signed(i) << (DATA_W−ADDR_W), giving i·16 for the defaults. With this table the unit is the identity function, except that it clamps at the positive end.
- Next-index rule, with idx the unsigned index:
  - idx = 2^(ADDR_W−1)−1 (largest positive): next = lut[idx]. The curve is flat past the top.
  - all other idx: next = lut[(idx+1) mod 2^ADDR_W]. The all-ones index (−1) therefore wraps to entry 0.
- Arithmetic:
  - diff = next − base, DATA_W+1 signed.
  - prod = diff × {0,frac}, DATA_W+FRAC_W+2 signed.
  - delta = (prod + 2^(FRAC_W−1)) >>> FRAC_W. This is round-half-up (arithmetic shift floors).
  - y = base + delta, truncated to DATA_W.
  - The result always lies between base and next, so no saturation logic is needed.
- Pipeline stages:
  - S0: register base, next and frac.
  - S1: register diff×frac and base.
  - S2: register y.
  - One valid flag per stage.
- Global stall: advance = !v2 || out_ready. All stages advance together. in_ready = advance.
- LUT write:
  - Takes effect on the clock edge of wr_en and is independent of the handshake. Writes are accepted during stall.
  - Write and S0 lookup of the same index in the same cycle: the lookup sees the old value.
  - Samples already past S0 are unaffected.
  - Two writes to one index on consecutive cycles: the last one wins.

## Timing
- Reset values: out_valid=0, out_y=0, all stage valids 0, LUT = ramp. in_ready=1 after reset because v2=0.
- Latency: 3 cycles from an in_valid&&in_ready edge to out_valid, with no stall. Throughput is 1 sample/cycle.
- Stall: while out_valid && !out_ready, all stages hold and in_ready=0. At most 3 samples are in flight. Order is preserved with no loss or duplication.
- Bubbles: a stage with valid 0 still advances, so empty slots collapse only at the output. in_ready depends only on v2 and out_ready. There is no combinational path from in_valid to in_ready.
- Reset asserted mid-stream: all in-flight samples are discarded immediately and out_valid drops asynchronously. The LUT reloads the ramp and loses any loaded curve.
- out_y holds its last value while out_valid=0.

## Structure
- Package `pwl_act_pkg`:
  - default widths;
  - function `ramp_entry(i)` for the reset table;
  - function `next_index(idx)` implementing the clamp/wrap rule, shared with the testbench model.
- Sub-module `pwl_act_lut`:
  - register array, one write port, two combinational read ports (base, next);
  - applies next_index internally;
  - asynchronous reset to ramp.
- Top `pwl_act_pipe` holds the three stages and the handshake.

## Test plan
All scenarios use default parameters.
1. Reset ramp, in_x=0x25 (37) → out_y=37 exactly 3 cycles after acceptance.
2. Reset ramp, in_x=0x7A (122) → out_y=112 (positive clamp). in_x=0x70 → 112.
3. Reset ramp, in_x=0xF8 (−8) → index 15 wraps to next=lut[0]: base −16, next 0, frac 8 → out_y=−8.
4. Write lut[2]=100, lut[3]=−100, then in_x=0x28 → out_y=0. Write lut[2]=−100, lut[3]=100 with the same in_x → out_y=0. Write lut[2]=10, lut[3]=11, in_x=0x28 → out_y=11 (half rounds up).
5. Stream x=1,2,3,4,5 back-to-back with out_ready held low for 6 cycles → in_ready drops once 3 samples are held. Outputs 1..5 appear in order with none lost. Also issue a write to an index in use during the stall; only samples entering S0 after the write see the new value.
6. Load lut[2]=100, stream samples, pulse rst_n low mid-stream → out_valid=0 immediately. After release lut[2]=32 again (in_x=0x20 → 32) and no stale outputs appear.
